// File: rtl/ps2_rx_decoder.sv
// PS/2 device-to-host receiver: synchronises the bus, validates each 11-bit frame,
// folds E0/F0 prefixes into flags and queues decoded keys in a first-word fall-through FIFO.
module ps2_rx_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          key_clock,
  input  logic                          data,
  input  logic                          rd_ready,
  output logic                          rd_valid,
  output logic [7:0]                    rd_code,
  output logic                          rd_ext,
  output logic                          rd_break,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          frame_err,
  output logic                          timeout_err,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [FW-1:0] FILL_ONE = FW'(1);
  localparam logic [FW-1:0] FILL_MAX = FW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  logic [SYNC_STAGES-1:0] kclk_sync_q, kclk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   kclk_prev_q, kclk_prev_d;
  logic                   kclk_s, data_s, fall;

  state_t                 state_q, state_d;
  logic [3:0]             count_q, count_d;
  logic [10:0]            shift_q, shift_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   ext_pend_q, ext_pend_d;
  logic                   brk_pend_q, brk_pend_d;
  logic                   frame_err_q, frame_err_d;
  logic                   timeout_err_q, timeout_err_d;
  logic                   overflow_q, overflow_d;

  logic [9:0]             mem_q [FIFO_DEPTH];
  logic [9:0]             mem_d [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]          fill_q, fill_d;

  logic                   frame_ok;
  logic [7:0]             frame_byte;
  logic                   push_req, push_ok, pop, full;
  logic [9:0]             head;

  assign kclk_s = kclk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = kclk_prev_q & ~kclk_s;

  always_comb begin
    kclk_sync_d = {kclk_sync_q[SYNC_STAGES-2:0], key_clock};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], data};
    kclk_prev_d = kclk_s;
  end

  // Shift register fills from the top, so after 11 bits: [0]=start, [8:1]=byte, [9]=parity, [10]=stop
  assign frame_byte = shift_q[8:1];
  assign frame_ok   = ~shift_q[0] & shift_q[10] & (^shift_q[9:1]);

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    shift_d       = shift_q;
    tmo_d         = tmo_q;
    ext_pend_d    = ext_pend_q;
    brk_pend_d    = brk_pend_q;
    frame_err_d   = 1'b0;
    timeout_err_d = 1'b0;
    push_req      = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (fall && !data_s) begin
          shift_d = {1'b0, 10'b0};
          count_d = 4'd1;
          state_d = RECV;
        end
      end
      RECV: begin
        if (fall) begin
          shift_d = {data_s, shift_q[10:1]};
          count_d = count_q + 4'd1;
          tmo_d   = '0;
          if (count_q == 4'd10) state_d = CHECK;
        end else if (tmo_q == TMO_LAST) begin
          // Stalled frame: drop it but keep any prefix already seen
          timeout_err_d = 1'b1;
          tmo_d         = '0;
          count_d       = '0;
          state_d       = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      CHECK: begin
        state_d = IDLE;
        count_d = '0;
        if (!frame_ok) begin
          frame_err_d = 1'b1;
          ext_pend_d  = 1'b0;
          brk_pend_d  = 1'b0;
        end else if (frame_byte == 8'hE0) begin
          ext_pend_d = 1'b1;
        end else if (frame_byte == 8'hF0) begin
          brk_pend_d = 1'b1;
        end else begin
          push_req   = 1'b1;
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign full     = (fill_q == FILL_MAX);
  assign rd_valid = (fill_q != '0);
  assign pop      = rd_valid & rd_ready;
  assign push_ok  = push_req & (~full | pop);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    overflow_d = push_req & full & ~pop;
    if (push_ok) begin
      mem_d[wr_ptr_q] = {ext_pend_q, brk_pend_q, frame_byte};
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_ok && !pop)      fill_d = fill_q + FILL_ONE;
    else if (pop && !push_ok) fill_d = fill_q - FILL_ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kclk_sync_q   <= '1;
      data_sync_q   <= '1;
      kclk_prev_q   <= 1'b1;
      state_q       <= IDLE;
      count_q       <= '0;
      shift_q       <= '0;
      tmo_q         <= '0;
      ext_pend_q    <= 1'b0;
      brk_pend_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      overflow_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fill_q        <= '0;
    end else begin
      kclk_sync_q   <= kclk_sync_d;
      data_sync_q   <= data_sync_d;
      kclk_prev_q   <= kclk_prev_d;
      state_q       <= state_d;
      count_q       <= count_d;
      shift_q       <= shift_d;
      tmo_q         <= tmo_d;
      ext_pend_q    <= ext_pend_d;
      brk_pend_q    <= brk_pend_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
      overflow_q    <= overflow_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fill_q        <= fill_d;
    end
  end

  // Stale entries stay in memory after a pop, so the head is masked when empty
  assign rd_code     = rd_valid ? head[7:0] : 8'h00;
  assign rd_break    = rd_valid & head[8];
  assign rd_ext      = rd_valid & head[9];
  assign fill_level  = fill_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_err_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Directed self-checking bench for ps2_rx_decoder with a short timeout and a 4-deep FIFO.
module tb_ps2_rx_decoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_clock = 1'b1;
  logic       data = 1'b1;
  logic       rd_ready = 1'b0;
  logic       rd_valid;
  logic [7:0] rd_code;
  logic       rd_ext;
  logic       rd_break;
  logic [2:0] fill_level;
  logic       frame_err;
  logic       timeout_err;
  logic       overflow;

  int assertCount = 0;
  int failCount = 0;
  int frameErrCnt = 0;
  int timeoutCnt = 0;
  int overflowCnt = 0;
  int base0, base1;

  ps2_rx_decoder #(
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(200),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .key_clock(key_clock),
    .data(data),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_code(rd_code),
    .rd_ext(rd_ext),
    .rd_break(rd_break),
    .fill_level(fill_level),
    .frame_err(frame_err),
    .timeout_err(timeout_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Pulse counters: a one-cycle pulse is seen on exactly one falling clock edge
  always @(negedge clk) begin
    if (frame_err)   frameErrCnt++;
    if (timeout_err) timeoutCnt++;
    if (overflow)    overflowCnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // mode 1 checks push latency on the stop bit, mode 2 pops during the CHECK cycle
  task automatic applyStimulus(input logic [10:0] frame, input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data = frame[i];
      repeat (10) @(negedge clk);
      key_clock = 1'b0;
      if (i == 10 && mode == 1) begin
        repeat (3) @(negedge clk);
        checkOutput("latency_before", 32'(rd_valid), 32'd0);
        @(negedge clk);
        checkOutput("latency_at", 32'(rd_valid), 32'd1);
        repeat (16) @(negedge clk);
      end else if (i == 10 && mode == 2) begin
        repeat (3) @(negedge clk);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        repeat (16) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
      key_clock = 1'b1;
      repeat (10) @(negedge clk);
    end
    data = 1'b1;
  endtask

  function automatic logic [10:0] makeFrame(input logic [7:0] code, input logic badPar, input logic stopBit);
    return {stopBit, (~^code) ^ badPar, code, 1'b0};
  endfunction

  task automatic sendKey(input logic [7:0] code);
    applyStimulus(makeFrame(code, 1'b0, 1'b1), 11, 0);
    repeat (5) @(negedge clk);
  endtask

  task automatic popOne(input string tag, input logic [7:0] code, input logic ext, input logic brk);
    checkOutput({tag, "_valid"}, 32'(rd_valid), 32'd1);
    checkOutput({tag, "_code"}, 32'(rd_code), 32'(code));
    checkOutput({tag, "_ext"}, 32'(rd_ext), 32'(ext));
    checkOutput({tag, "_break"}, 32'(rd_break), 32'(brk));
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, 32'(rd_valid), 32'd0);
    checkOutput({tag, "_code"}, 32'(rd_code), 32'd0);
    checkOutput({tag, "_flags"}, 32'({rd_ext, rd_break}), 32'd0);
    checkOutput({tag, "_fill"}, 32'(fill_level), 32'd0);
    checkOutput({tag, "_pulses"}, 32'({frame_err, timeout_err, overflow}), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Plain make code with latency check, then a single pop
    applyStimulus(makeFrame(8'h1C, 1'b0, 1'b1), 11, 1);
    repeat (5) @(negedge clk);
    checkOutput("make_fill", 32'(fill_level), 32'd1);
    popOne("make", 8'h1C, 1'b0, 1'b0);
    checkOutput("make_empty_valid", 32'(rd_valid), 32'd0);
    checkOutput("make_empty_fill", 32'(fill_level), 32'd0);

    // Prefix folding
    sendKey(8'hF0);
    checkOutput("brk_prefix_fill", 32'(fill_level), 32'd0);
    sendKey(8'h1C);
    checkOutput("brk_fill", 32'(fill_level), 32'd1);
    popOne("brk", 8'h1C, 1'b0, 1'b1);
    sendKey(8'hE0);
    checkOutput("extbrk_e0_fill", 32'(fill_level), 32'd0);
    sendKey(8'hF0);
    checkOutput("extbrk_f0_fill", 32'(fill_level), 32'd0);
    sendKey(8'h75);
    checkOutput("extbrk_fill", 32'(fill_level), 32'd1);
    popOne("extbrk", 8'h75, 1'b1, 1'b1);
    sendKey(8'hE0);
    sendKey(8'h75);
    checkOutput("ext_fill", 32'(fill_level), 32'd1);
    popOne("ext", 8'h75, 1'b1, 1'b0);

    // Bad parity, then a bad stop bit clearing a pending break prefix
    base0 = frameErrCnt;
    applyStimulus(makeFrame(8'h1C, 1'b1, 1'b1), 11, 0);
    repeat (5) @(negedge clk);
    checkOutput("parity_err_pulses", 32'(frameErrCnt - base0), 32'd1);
    checkOutput("parity_err_fill", 32'(fill_level), 32'd0);
    sendKey(8'hF0);
    applyStimulus(makeFrame(8'h1C, 1'b0, 1'b0), 11, 0);
    repeat (5) @(negedge clk);
    checkOutput("stop_err_pulses", 32'(frameErrCnt - base0), 32'd2);
    sendKey(8'h1C);
    popOne("after_err", 8'h1C, 1'b0, 1'b0);

    // Stalled partial frame
    base0 = timeoutCnt;
    base1 = frameErrCnt;
    applyStimulus(makeFrame(8'h29, 1'b0, 1'b1), 5, 0);
    repeat (300) @(negedge clk);
    checkOutput("timeout_pulses", 32'(timeoutCnt - base0), 32'd1);
    checkOutput("timeout_no_ferr", 32'(frameErrCnt - base1), 32'd0);
    checkOutput("timeout_fill", 32'(fill_level), 32'd0);
    sendKey(8'h29);
    popOne("after_timeout", 8'h29, 1'b0, 1'b0);

    // Overflow with rd_ready held low
    base0 = overflowCnt;
    sendKey(8'h16);
    sendKey(8'h1E);
    sendKey(8'h26);
    sendKey(8'h25);
    checkOutput("full_fill", 32'(fill_level), 32'd4);
    checkOutput("full_no_ovf", 32'(overflowCnt - base0), 32'd0);
    sendKey(8'h2E);
    checkOutput("ovf_pulses", 32'(overflowCnt - base0), 32'd1);
    checkOutput("ovf_fill", 32'(fill_level), 32'd4);
    popOne("drain0", 8'h16, 1'b0, 1'b0);
    popOne("drain1", 8'h1E, 1'b0, 1'b0);
    popOne("drain2", 8'h26, 1'b0, 1'b0);
    popOne("drain3", 8'h25, 1'b0, 1'b0);
    checkOutput("drain_fill", 32'(fill_level), 32'd0);

    // Simultaneous push and pop while full
    base0 = overflowCnt;
    sendKey(8'h16);
    sendKey(8'h1E);
    sendKey(8'h26);
    sendKey(8'h25);
    applyStimulus(makeFrame(8'h2E, 1'b0, 1'b1), 11, 2);
    repeat (5) @(negedge clk);
    checkOutput("pushpop_no_ovf", 32'(overflowCnt - base0), 32'd0);
    checkOutput("pushpop_fill", 32'(fill_level), 32'd4);
    popOne("pushpop0", 8'h1E, 1'b0, 1'b0);
    popOne("pushpop1", 8'h26, 1'b0, 1'b0);
    popOne("pushpop2", 8'h25, 1'b0, 1'b0);
    popOne("pushpop3", 8'h2E, 1'b0, 1'b0);

    // Reset mid-frame with a queued key and a pending extended prefix
    sendKey(8'h16);
    sendKey(8'hE0);
    applyStimulus(makeFrame(8'h1C, 1'b0, 1'b1), 3, 0);
    reset_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    sendKey(8'h1C);
    checkOutput("post_reset_fill", 32'(fill_level), 32'd1);
    popOne("post_reset", 8'h1C, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/ps2_rx_decoder.md
Name: ps2_rx_decoder

Overview:
- Parametrised successor to the single-shot PS/2 keyboard FSM.
- Receives continuous PS/2 device-to-host frames:
  - synchronises key_clock and data into clk;
  - checks start, stop and odd parity;
  - times out stalled frames;
  - folds E0 (extended) and F0 (break) prefixes into flags on the following code.
- Decoded keys go into a FIFO with a valid/ready read port, which feeds the game/display logic.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on key_clock and data (min 2).
- TIMEOUT_CYCLES, 100000, clk cycles with no falling edge before a partial frame is aborted (2 ms at 50 MHz).
- FIFO_DEPTH, 8, decoded-key entries; power of 2, min 2.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- key_clock  input  1  raw PS/2 clock, asynchronous
- data  input  1  raw PS/2 data, asynchronous
- rd_ready  input  1  consumer accepts the head entry
- rd_valid  output  1  FIFO non-empty
- rd_code  output  8  head scan code
- rd_ext  output  1  head code was preceded by E0
- rd_break  output  1  head code was preceded by F0
- fill_level  output  $clog2(FIFO_DEPTH)+1  entries held
- frame_err  output  1  one-cycle pulse on bad start, stop or parity
- timeout_err  output  1  one-cycle pulse on aborted partial frame
- overflow  output  1  one-cycle pulse when a decoded key is dropped

Behaviour:
- Reset (async assert, sync release):
  - synchroniser flops go to 1;
  - FSM goes to IDLE; bit count, timeout counter, ext_pend and brk_pend go to 0;
  - FIFO empties;
  - all outputs 0: rd_valid, rd_code, rd_ext, rd_break, fill_level, and the three error pulses.
- Reset mid-frame discards the partial frame and all FIFO contents.
- Edge detect: a falling edge is synced key_clock previous=1, current=0. The synced data bit is sampled in that same cycle.
- Frame FSM states: IDLE, RECV, CHECK.
  - IDLE: on a falling edge with data=0, capture the start bit, set count=1, go to RECV. On a falling edge with data=1, stay in IDLE (glitch, no error).
  - RECV: each falling edge shifts the bit in LSB-first (data bits 0..7, then parity, then stop) and increments count. When the 11th bit is captured, go to CHECK.
  - RECV timeout: the counter clears on every falling edge and increments otherwise. At TIMEOUT_CYCLES, pulse timeout_err, discard the frame, go to IDLE. Prefix flags are kept.
  - CHECK (exactly one cycle), then always back to IDLE:
    - The frame is valid when start=0, stop=1, and the XOR of the 8 data bits and the parity bit is 1.
    - Invalid: pulse frame_err, clear ext_pend and brk_pend, push nothing.
    - Valid byte E0: set ext_pend, push nothing.
    - Valid byte F0: set brk_pend, push nothing.
    - Any other valid byte (including E1): push {ext_pend, brk_pend, byte}, then clear both flags.
- Latency: the stop bit is sampled at cycle N, CHECK occurs at N+1, and the entry is visible at N+2 (rd_valid=1 if the FIFO was empty). This is excluding synchroniser delay.
- FIFO:
  - 10-bit entries, first-word fall-through; rd_* show the head whenever rd_valid=1.
  - Pop when rd_valid and rd_ready are both high. rd_ready while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - fill_level changes by +1 on push only, -1 on pop only, and is unchanged on both.
  - Push while full with no pop: the entry is dropped, overflow pulses, contents unchanged.
  - Push while full with a pop in the same cycle: both occur, no overflow, fill_level stays FIFO_DEPTH.
- The receiver never stalls on FIFO state; a byte arriving during CHECK is impossible (≥1 PS/2 bit period apart).

Test Plan:
- Make code: send frame start 0, data 0x1C LSB-first (0,0,1,1,1,0,0,0), parity 0, stop 1 -> rd_valid=1 two cycles after the synced stop edge; rd_code=0x1C, rd_ext=0, rd_break=0, fill_level=1. rd_ready=1 for one cycle -> rd_valid=0, fill_level=0.
- Prefixes:
  - send F0, 1C -> a single entry with code 0x1C, break=1, ext=0;
  - send E0, F0, 75 -> a single entry with code 0x75, ext=1, break=1;
  - send E0, 75 -> ext=1, break=0;
  - fill_level increments only on the final byte of each sequence.
- Errors:
  - 0x1C with parity 1 -> one-cycle frame_err, no push;
  - F0 followed by a frame with stop=0 -> frame_err; then a good 0x1C arrives with break=0.
- Timeout: TIMEOUT_CYCLES=200, send 5 bits then idle -> timeout_err pulses once, FSM returns to IDLE; the next full 0x29 frame decodes correctly.
- Overflow: FIFO_DEPTH=4, rd_ready=0, send 0x16, 0x1E, 0x26, 0x25, 0x2E -> overflow pulses on the 5th, fill_level=4; draining yields 0x16, 0x1E, 0x26, 0x25 in order.
- Full push+pop and reset:
  - with the FIFO full, hold rd_ready=1 across the CHECK cycle of a new key -> no overflow, fill_level stays 4, the new code ends up last;
  - pulse reset_n low mid-frame -> outputs 0 immediately, and the next frame decodes normally.
